// File: rtl/dmem_req_ctrl.sv
// Data-side memory request issuer: one outstanding load/store on an SRAM-like
// req/addr_ok/data_ok bus, with store lane formatting and flush cancellation.
module dmem_req_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_mem_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic              in_exc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_rdata,
    output logic              out_ale,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [3:0]        data_wstrb,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e state_q, state_d;
    logic   cancel_q, cancel_d;

    logic              wr_q;
    logic [1:0]        size_q;
    logic [3:0]        wstrb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              ale_q;

    logic        is_byte, is_half, is_word, is_store;
    logic        ale, skip_bus, accept, resp_kept;
    logic [1:0]  size_new;
    logic [3:0]  wstrb_new;
    logic [31:0] wdata_new;

    assign is_byte  = in_mem_op[0] | in_mem_op[3] | in_mem_op[5];
    assign is_half  = in_mem_op[1] | in_mem_op[4] | in_mem_op[6];
    assign is_word  = in_mem_op[2] | in_mem_op[7];
    assign is_store = |in_mem_op[7:5];
    assign ale      = (is_half && in_addr[0]) || (is_word && (in_addr[1:0] != 2'b00));
    assign skip_bus = ale || in_exc;
    // flush blocks acceptance even while in_ready is shown high in IDLE
    assign accept   = in_valid && in_ready && !flush;
    // A response is only kept if no flush hit this transaction
    assign resp_kept = (state_q == S_WAIT) && data_data_ok && !cancel_q && !flush;

    // Store lane formatting; loads carry no strobes and no data
    always_comb begin
        // NOTE: every combinationally driven signal gets a default first so no latch is inferred.
        size_new  = 2'd0;
        wstrb_new = 4'b0000;
        wdata_new = 32'h0;
        if (is_half) size_new = 2'd1;
        if (is_word) size_new = 2'd2;
        if (in_mem_op[5]) begin
            wstrb_new = 4'b0001 << in_addr[1:0];
            wdata_new = {4{in_wdata[7:0]}};
        end else if (in_mem_op[6]) begin
            wstrb_new = in_addr[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{in_wdata[15:0]}};
        end else if (in_mem_op[7]) begin
            wstrb_new = 4'b1111;
            wdata_new = in_wdata;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops sample together.
        if (!rst) begin
            state_q  <= S_IDLE;
            cancel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = skip_bus ? S_HOLD : S_REQ;
            end
            S_REQ: begin
                if (flush)        cancel_d = 1'b1;
                if (data_addr_ok) state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (flush) cancel_d = 1'b1;
                if (data_data_ok) begin
                    cancel_d = 1'b0;
                    state_d  = (cancel_q || flush) ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    if (accept) state_d = skip_bus ? S_HOLD : S_REQ;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (state_q == S_IDLE) ||
                    ((state_q == S_HOLD) && out_ready && !flush);
        data_req  = (state_q == S_REQ);
        out_valid = (state_q == S_HOLD);
        out_ale   = (state_q == S_HOLD) && ale_q;
    end

    // Captured request fields and the returned word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            wstrb_q <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ale_q   <= 1'b0;
        end else if (accept) begin
            wr_q    <= is_store;
            size_q  <= size_new;
            wstrb_q <= wstrb_new;
            addr_q  <= in_addr;
            wdata_q <= wdata_new;
            rdata_q <= 32'h0;
            ale_q   <= ale;
        end else if (resp_kept) begin
            rdata_q <= wr_q ? 32'h0 : data_rdata;
        end
    end

    assign data_wr    = wr_q;
    assign data_size  = size_q;
    assign data_wstrb = wstrb_q;
    assign data_addr  = addr_q;
    assign data_wdata = wdata_q;
    assign out_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl: a vector table of single ops plus hand-written
// sequences for stalls, flushes, simultaneous bus events and asynchronous reset.
module tb_dmem_req_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_mem_op = 8'h0;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_wdata = 32'h0;
    logic        in_exc = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_ale;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok = 1'b0;
    logic        data_data_ok = 1'b0;
    logic [31:0] data_rdata = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [7:0] OP_LB  = 8'h01, OP_LH  = 8'h02, OP_LW = 8'h04, OP_LBU = 8'h08;
    localparam logic [7:0] OP_LHU = 8'h10, OP_SB  = 8'h20, OP_SH = 8'h40, OP_SW  = 8'h80;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exc;
        logic [31:0] bus_rdata;
        logic        exp_skip;
        logic        exp_ale;
        logic        exp_wr;
        logic [1:0]  exp_size;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    dmem_req_ctrl #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mem_op    (in_mem_op),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_exc       (in_exc),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rdata    (out_rdata),
        .out_ale      (out_ale),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exc);
        in_valid  = 1'b1;
        in_mem_op = op;
        in_addr   = addr;
        in_wdata  = wdata;
        in_exc    = exc;
        step();
        in_valid  = 1'b0;
        in_exc    = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{OP_LW,  32'h1000, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{OP_SB,  32'h1003, 32'h000000A5, 1'b0, 32'h55555555, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{OP_SH,  32'h1002, 32'h00001234, 1'b0, 32'h55555555, 1'b0, 1'b0, 1'b1, 2'd1, 4'b1100, 32'h12341234, 32'h0};
        vecs[3]  = '{OP_SH,  32'h1000, 32'hFFFF5678, 1'b0, 32'h55555555, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0011, 32'h56785678, 32'h0};
        vecs[4]  = '{OP_SW,  32'h2004, 32'hCAFEF00D, 1'b0, 32'h55555555, 1'b0, 1'b0, 1'b1, 2'd2, 4'b1111, 32'hCAFEF00D, 32'h0};
        vecs[5]  = '{OP_SB,  32'h2001, 32'h11223344, 1'b0, 32'h55555555, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0010, 32'h44444444, 32'h0};
        vecs[6]  = '{OP_LB,  32'h3003, 32'h0,        1'b0, 32'h80FF0011, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'h80FF0011};
        vecs[7]  = '{OP_LHU, 32'h3002, 32'h0,        1'b0, 32'h13579BDF, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 32'h0,        32'h13579BDF};
        vecs[8]  = '{OP_LBU, 32'h1001, 32'h0,        1'b0, 32'hA1B2C3D4, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0,        32'hA1B2C3D4};
        vecs[9]  = '{OP_LH,  32'h1001, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd1, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{OP_LW,  32'h1002, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{OP_SW,  32'h1001, 32'h87654321, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd2, 4'b1111, 32'h0,        32'h0};
        vecs[12] = '{OP_LW,  32'h1000, 32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 32'h0,        32'h0};
        vecs[13] = '{OP_SH,  32'h1003, 32'h0000BEEF, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 2'd1, 4'b1100, 32'h0,        32'h0};

        // Reset state
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_data_req",  {31'b0, data_req},  32'h0);
        check("rst_out_rdata", out_rdata,          32'h0);
        check("rst_out_ale",   {31'b0, out_ale},   32'h0);
        rst = 1'b1;
        step();
        check("rst_in_ready",  {31'b0, in_ready},  32'h1);

        // Table-driven single operations
        for (int i = 0; i < 14; i++) begin
            check($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
            issue(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].exc);
            if (vecs[i].exp_skip) begin
                check($sformatf("v%0d_no_req", i),    {31'b0, data_req},  32'h0);
                check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'h1);
                check($sformatf("v%0d_out_ale", i),   {31'b0, out_ale},   {31'b0, vecs[i].exp_ale});
                check($sformatf("v%0d_out_rdata", i), out_rdata,          32'h0);
            end else begin
                check($sformatf("v%0d_req", i),   {31'b0, data_req},   32'h1);
                check($sformatf("v%0d_wr", i),    {31'b0, data_wr},    {31'b0, vecs[i].exp_wr});
                check($sformatf("v%0d_size", i),  {30'b0, data_size},  {30'b0, vecs[i].exp_size});
                check($sformatf("v%0d_wstrb", i), {28'b0, data_wstrb}, {28'b0, vecs[i].exp_wstrb});
                check($sformatf("v%0d_addr", i),  data_addr,           vecs[i].addr);
                if (vecs[i].exp_wr)
                    check($sformatf("v%0d_wdata", i), data_wdata, vecs[i].exp_wdata);
                data_addr_ok = 1'b1;
                step();
                data_addr_ok = 1'b0;
                check($sformatf("v%0d_wait_req", i),   {31'b0, data_req},  32'h0);
                check($sformatf("v%0d_wait_valid", i), {31'b0, out_valid}, 32'h0);
                data_data_ok = 1'b1;
                data_rdata   = vecs[i].bus_rdata;
                step();
                data_data_ok = 1'b0;
                data_rdata   = 32'hBAD0BAD0;
                check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, 32'h1);
                check($sformatf("v%0d_out_rdata", i), out_rdata,          vecs[i].exp_rdata);
                check($sformatf("v%0d_out_ale", i),   {31'b0, out_ale},   32'h0);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check($sformatf("v%0d_drained", i), {31'b0, out_valid}, 32'h0);
        end

        // Flush while addr_ok is held low: req stays up, response is dropped
        issue(OP_LW, 32'h1000, 32'h0, 1'b0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_req_held",  {31'b0, data_req}, 32'h1);
        check("fl_no_ready",  {31'b0, in_ready}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("fl_req_c%0d", k),   {31'b0, data_req},  32'h1);
            check($sformatf("fl_valid_c%0d", k), {31'b0, out_valid}, 32'h0);
        end
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check("fl_wait_ready", {31'b0, in_ready}, 32'h0);
        data_data_ok = 1'b1;
        data_rdata   = 32'h12345678;
        step();
        data_data_ok = 1'b0;
        check("fl_dropped",  {31'b0, out_valid}, 32'h0);
        check("fl_ready",    {31'b0, in_ready},  32'h1);
        step();
        check("fl_still_no_valid", {31'b0, out_valid}, 32'h0);

        // Flush coinciding with data_ok in WAIT
        issue(OP_LW, 32'h1004, 32'h0, 1'b0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        flush        = 1'b1;
        step();
        data_data_ok = 1'b0;
        flush        = 1'b0;
        check("fld_no_valid", {31'b0, out_valid}, 32'h0);
        check("fld_ready",    {31'b0, in_ready},  32'h1);

        // addr_ok and data_ok together in REQ: data_ok ignored there
        issue(OP_LW, 32'h1008, 32'h0, 1'b0);
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'hAAAA0000;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        check("sim_no_valid", {31'b0, out_valid}, 32'h0);
        check("sim_in_wait",  {31'b0, data_req},  32'h0);
        data_data_ok = 1'b1;
        data_rdata   = 32'h0BADF00D;
        step();
        data_data_ok = 1'b0;
        check("sim_valid", {31'b0, out_valid}, 32'h1);
        check("sim_rdata", out_rdata,          32'h0BADF00D);

        // Stall in HOLD for 3 cycles
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("st_valid_c%0d", k), {31'b0, out_valid}, 32'h1);
            check($sformatf("st_rdata_c%0d", k), out_rdata,          32'h0BADF00D);
            check($sformatf("st_ready_c%0d", k), {31'b0, in_ready},  32'h0);
        end

        // Back-to-back: response drained and a store accepted in the same cycle
        out_ready = 1'b1;
        #0;
        check("b2b_in_ready", {31'b0, in_ready}, 32'h1);
        issue(OP_SW, 32'h200C, 32'h01020304, 1'b0);
        out_ready = 1'b0;
        check("b2b_req",   {31'b0, data_req},  32'h1);
        check("b2b_valid", {31'b0, out_valid}, 32'h0);
        check("b2b_wdata", data_wdata,         32'h01020304);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        step();
        data_data_ok = 1'b0;
        check("b2b_store_valid", {31'b0, out_valid}, 32'h1);
        check("b2b_store_rdata", out_rdata,          32'h0);

        // Flush in HOLD clears out_valid
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flh_valid", {31'b0, out_valid}, 32'h0);
        check("flh_ready", {31'b0, in_ready},  32'h1);

        // Asynchronous reset mid-WAIT
        issue(OP_LW, 32'h1010, 32'h0, 1'b0);
        data_addr_ok = 1'b1;
        step();
        data_addr_ok = 1'b0;
        check("rw_in_wait", {31'b0, in_ready}, 32'h0);
        #2 rst = 1'b0;
        #1;
        check("rw_ready",  {31'b0, in_ready},  32'h1);
        check("rw_valid",  {31'b0, out_valid}, 32'h0);
        check("rw_req",    {31'b0, data_req},  32'h0);
        check("rw_rdata",  out_rdata,          32'h0);
        step();
        rst = 1'b1;
        step();

        // Asynchronous reset while an ALE response is held
        issue(OP_LH, 32'h1001, 32'h0, 1'b0);
        check("rh_ale_pre", {31'b0, out_ale}, 32'h1);
        #2 rst = 1'b0;
        #1;
        check("rh_ale",   {31'b0, out_ale},   32'h0);
        check("rh_valid", {31'b0, out_valid}, 32'h0);
        step();
        rst = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
